// File: rtl/gcn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gcn_pkg : shared FSM state type and default sizes for the GCN argmax  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package gcn_pkg;

  localparam int ROWS              = 6;
  localparam int COLS              = 3;
  localparam int DATA_WIDTH        = 16;
  localparam int MAX_ADDRESS_WIDTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/gcn_argmax_ctrl_argmax_row.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | argmax_row : combinational argmax over one row, lowest index on ties  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module argmax_row
  import gcn_pkg::*;
#(
  parameter int COLS              = gcn_pkg::COLS,
  parameter int DATA_WIDTH        = gcn_pkg::DATA_WIDTH,
  parameter int MAX_ADDRESS_WIDTH = gcn_pkg::MAX_ADDRESS_WIDTH
) (
  input  logic [DATA_WIDTH-1:0]        values [0:COLS-1],
  output logic [MAX_ADDRESS_WIDTH-1:0] index
);

  logic [DATA_WIDTH-1:0] best;

  // Strict greater-than keeps the earliest column on equal values.
  always_comb begin
    best  = values[0];
    index = '0;
    for (int i = 1; i < COLS; i++) begin
      if (values[i] > best) begin
        best  = values[i];
        index = MAX_ADDRESS_WIDTH'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/gcn_argmax_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gcn_argmax_ctrl : walks the result buffer and records per-row argmax  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module gcn_argmax_ctrl
  import gcn_pkg::*;
#(
  parameter int ROWS              = gcn_pkg::ROWS,
  parameter int COLS              = gcn_pkg::COLS,
  parameter int DATA_WIDTH        = gcn_pkg::DATA_WIDTH,
  parameter int MAX_ADDRESS_WIDTH = gcn_pkg::MAX_ADDRESS_WIDTH,
  parameter int ROW_ADDR_WIDTH    = 3,
  parameter int RD_LATENCY        = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         rd_en,
  output logic [ROW_ADDR_WIDTH-1:0]    rd_addr,
  input  logic [DATA_WIDTH-1:0]        rd_data [0:COLS-1],
  output logic [MAX_ADDRESS_WIDTH-1:0] max_addi_answer [0:ROWS-1],
  output logic                         busy,
  output logic                         done
);

  localparam int RET_WIDTH = $clog2(ROWS + 1);
  localparam logic [ROW_ADDR_WIDTH-1:0] LAST_ROW = ROW_ADDR_WIDTH'(ROWS - 1);
  localparam logic [RET_WIDTH-1:0]      LAST_RET = RET_WIDTH'(ROWS - 1);

  state_t                         state, state_nxt;
  logic [ROW_ADDR_WIDTH-1:0]      issue_cnt;
  logic [RET_WIDTH-1:0]           retire_cnt;
  logic [RD_LATENCY-1:0]          pipe_vld;
  logic [ROW_ADDR_WIDTH-1:0]      pipe_row [RD_LATENCY];
  logic [MAX_ADDRESS_WIDTH-1:0]   row_idx;
  logic                           retire;
  logic                           last_retire;

  assign rd_addr     = issue_cnt;
  assign retire      = pipe_vld[RD_LATENCY-1];
  assign last_retire = retire && (retire_cnt == LAST_RET);

  argmax_row #(
    .COLS              (COLS),
    .DATA_WIDTH        (DATA_WIDTH),
    .MAX_ADDRESS_WIDTH (MAX_ADDRESS_WIDTH)
  ) u_argmax_row (
    .values (rd_data),
    .index  (row_idx)
  );

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        rd_en = 1'b1;
        busy  = 1'b1;
        if (issue_cnt == LAST_ROW) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (last_retire) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      issue_cnt  <= '0;
      retire_cnt <= '0;
      pipe_vld   <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_row[i] <= '0;
      for (int r = 0; r < ROWS; r++) max_addi_answer[r] <= '0;
    end else begin
      state       <= state_nxt;
      pipe_vld[0] <= rd_en;
      pipe_row[0] <= issue_cnt;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_row[i] <= pipe_row[i-1];
      end
      if (state == IDLE && start) begin
        issue_cnt  <= '0;
        retire_cnt <= '0;
        for (int r = 0; r < ROWS; r++) max_addi_answer[r] <= '0;
      end
      // Saturates on the last row so rd_addr keeps it after the issue phase.
      if (state == ISSUE && issue_cnt != LAST_ROW) issue_cnt <= issue_cnt + 1'b1;
      if (retire) begin
        retire_cnt                                <= retire_cnt + 1'b1;
        max_addi_answer[pipe_row[RD_LATENCY-1]]   <= row_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gcn_argmax_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gcn_argmax_ctrl : directed bench for latency 1 and latency 3       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_gcn_argmax_ctrl;

  localparam int R  = 6;
  localparam int C  = 3;
  localparam int DW = 16;
  localparam int MW = 2;
  localparam int AW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst    = 1'b1;
  logic          start1 = 1'b0;
  logic          start3 = 1'b0;
  logic          rd_en1, rd_en3, busy1, busy3, done1, done3;
  logic [AW-1:0] rd_addr1, rd_addr3;
  logic [DW-1:0] rd_data1 [0:C-1];
  logic [DW-1:0] rd_data3 [0:C-1];
  logic [MW-1:0] ans1 [0:R-1];
  logic [MW-1:0] ans3 [0:R-1];

  logic [DW-1:0] mem   [0:R-1][0:C-1];
  logic [MW-1:0] exp_a [0:R-1];
  int n_assert = 0;
  int n_fail   = 0;

  gcn_argmax_ctrl #(.ROW_ADDR_WIDTH(AW), .RD_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .rd_en(rd_en1), .rd_addr(rd_addr1),
    .rd_data(rd_data1), .max_addi_answer(ans1), .busy(busy1), .done(done1)
  );

  gcn_argmax_ctrl #(.ROW_ADDR_WIDTH(AW), .RD_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .rd_en(rd_en3), .rd_addr(rd_addr3),
    .rd_data(rd_data3), .max_addi_answer(ans3), .busy(busy3), .done(done3)
  );

  // Buffer models; outside the valid window they return {0,0,FFFF} so an early capture shows up.
  logic          v1;
  logic [AW-1:0] a1;
  logic [2:0]    v3;
  logic [AW-1:0] a3 [0:2];
  initial begin
    v1 = 1'b0; a1 = '0; v3 = '0;
    for (int i = 0; i < 3; i++) a3[i] = '0;
  end
  always @(posedge clk) begin
    v1    <= rd_en1;
    a1    <= rd_addr1;
    v3    <= {v3[1:0], rd_en3};
    a3[0] <= rd_addr3;
    a3[1] <= a3[0];
    a3[2] <= a3[1];
  end
  always_comb begin
    for (int c = 0; c < C; c++) begin
      rd_data1[c] = v1    ? mem[a1][c]    : ((c == C-1) ? 16'hFFFF : 16'h0000);
      rd_data3[c] = v3[2] ? mem[a3[2]][c] : ((c == C-1) ? 16'hFFFF : 16'h0000);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_basic();
    mem   = '{'{16'd5, 16'd9, 16'd2}, '{16'd7, 16'd1, 16'd3}, '{16'd0, 16'd0, 16'd8},
              '{16'd4, 16'd4, 16'd1}, '{16'd2, 16'd6, 16'd6}, '{16'd3, 16'd3, 16'd3}};
    exp_a = '{2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0};
  endtask

  task automatic load_extreme();
    mem   = '{'{16'hFFFF, 16'h0000, 16'hFFFE}, '{16'h0000, 16'h0000, 16'hFFFF},
              '{16'h8000, 16'h7FFF, 16'h0000}, '{16'h0000, 16'h8000, 16'h7FFF},
              '{16'd1, 16'd2, 16'd3}, '{16'd3, 16'd3, 16'd2}};
    exp_a = '{2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
  endtask

  task automatic chk_ans1(input string tag);
    for (int r = 0; r < R; r++) chk($sformatf("%s ans1[%0d]", tag, r), ans1[r], exp_a[r]);
  endtask

  task automatic chk_zero1(input string tag);
    for (int r = 0; r < R; r++) chk($sformatf("%s ans1[%0d]", tag, r), ans1[r], 0);
  endtask

  initial begin
    load_basic();
    // Reset state
    repeat (3) tick();
    chk("rst rd_en1", rd_en1, 0);
    chk("rst rd_addr1", rd_addr1, 0);
    chk("rst busy1", busy1, 0);
    chk("rst done1", done1, 0);
    chk("rst busy3", busy3, 0);
    chk_zero1("rst");
    for (int r = 0; r < R; r++) chk($sformatf("rst ans3[%0d]", r), ans3[r], 0);
    rst = 1'b0;
    tick();

    // Basic run on both latencies, cycle by cycle
    start1 = 1'b1; start3 = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      if (cyc == 1) begin start1 = 1'b0; start3 = 1'b0; end
      chk($sformatf("basic rd_en1 c%0d", cyc), rd_en1, (cyc <= 6));
      chk($sformatf("basic rd_addr1 c%0d", cyc), rd_addr1, (cyc <= 6) ? cyc - 1 : 5);
      chk($sformatf("basic busy1 c%0d", cyc), busy1, (cyc <= 8));
      chk($sformatf("basic done1 c%0d", cyc), done1, (cyc == 8));
      chk($sformatf("basic rd_en3 c%0d", cyc), rd_en3, (cyc <= 6));
      chk($sformatf("basic busy3 c%0d", cyc), busy3, (cyc <= 10));
      chk($sformatf("basic done3 c%0d", cyc), done3, (cyc == 10));
      for (int k = 0; k < R; k++) begin
        chk($sformatf("basic ans1[%0d] c%0d", k, cyc), ans1[k], (cyc >= k + 3) ? exp_a[k] : 0);
        chk($sformatf("basic ans3[%0d] c%0d", k, cyc), ans3[k], (cyc >= k + 5) ? exp_a[k] : 0);
      end
    end

    // Start while busy, then an accepted restart in cycle 9 on extreme data
    start1 = 1'b1;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      tick();
      if (cyc == 1)  start1 = 1'b0;
      if (cyc == 3)  start1 = 1'b1;
      if (cyc == 4)  start1 = 1'b0;
      if (cyc == 8)  start1 = 1'b1;
      if (cyc == 10) start1 = 1'b0;
      chk($sformatf("busy-start done1 c%0d", cyc), done1, (cyc == 8 || cyc == 17));
      chk($sformatf("busy-start rd_en1 c%0d", cyc), rd_en1,
          ((cyc >= 1 && cyc <= 6) || (cyc >= 10 && cyc <= 15)));
      chk($sformatf("busy-start busy1 c%0d", cyc), busy1,
          ((cyc >= 1 && cyc <= 8) || (cyc >= 10 && cyc <= 17)));
      if (cyc == 8) chk_ans1("busy-start first");
      if (cyc == 9) load_extreme();
      if (cyc == 10 || cyc == 11) chk_zero1($sformatf("restart clear c%0d", cyc));
      if (cyc == 17) chk_ans1("extreme");
    end

    // Reset mid-run, then a clean run
    load_basic();
    start1 = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      if (cyc == 1) start1 = 1'b0;
      if (cyc == 4) begin
        chk("midrst ans1[0] before", ans1[0], 1);
        rst = 1'b1;
      end
      if (cyc == 5) begin
        rst = 1'b0;
        chk_zero1("midrst");
      end
      if (cyc >= 5) begin
        chk($sformatf("midrst rd_en1 c%0d", cyc), rd_en1, 0);
        chk($sformatf("midrst busy1 c%0d", cyc), busy1, 0);
      end
      chk($sformatf("midrst done1 c%0d", cyc), done1, 0);
    end
    start1 = 1'b1;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      tick();
      if (cyc == 1) start1 = 1'b0;
      chk($sformatf("post-rst done1 c%0d", cyc), done1, (cyc == 8));
      if (cyc == 8) chk_ans1("post-rst");
    end
    chk("post-rst idle busy1", busy1, 0);

    // Back-to-back with start held high
    start1 = 1'b1;
    for (int cyc = 1; cyc <= 36; cyc++) begin
      int m;
      tick();
      if (cyc == 28) start1 = 1'b0;
      m = cyc % 9;
      chk($sformatf("b2b rd_en1 c%0d", cyc), rd_en1, (m >= 1 && m <= 6));
      chk($sformatf("b2b done1 c%0d", cyc), done1, (m == 8));
      chk($sformatf("b2b busy1 c%0d", cyc), busy1, (m != 0));
      if (m == 8) chk_ans1($sformatf("b2b c%0d", cyc));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
